// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder
// Hunts for a sync byte in the UART receiver's byte stream, parses a
// length-prefixed payload with an XOR checksum, streams payload bytes to the
// panel buffer write port and reports each frame with a pass/fail pulse.
// Optional build macro: FRAME_TIMEOUT_EN adds an inter-byte gap timeout that
// aborts a partial frame with o_Frame_Err.
module uart_frame_decoder #(
    parameter int unsigned CLKS_PER_BIT  = 217,
    parameter int unsigned MAX_LEN       = 64,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int unsigned TIMEOUT_BYTES = 10
) (
    input  logic                       i_Clock,
    input  logic                       i_Rst_L,
    input  logic                       i_RX_DV,
    input  logic [7:0]                 i_RX_Byte,
    output logic                       o_Wr_En,
    output logic [$clog2(MAX_LEN)-1:0] o_Wr_Addr,
    output logic [7:0]                 o_Wr_Data,
    output logic                       o_Frame_Done,
    output logic                       o_Frame_Err,
    output logic [7:0]                 o_Frame_Len
);

    localparam int unsigned ADDR_W       = $clog2(MAX_LEN);
    localparam logic [8:0]  MAX_LEN_9    = 9'(MAX_LEN);
    localparam int unsigned TIMEOUT_CLKS = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;

    typedef enum logic [1:0] {
        IDLE,
        GET_LEN,
        GET_DATA,
        GET_CHK
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          chk_q, chk_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [7:0]          frame_len_q, frame_len_d;

`ifdef FRAME_TIMEOUT_EN
    localparam int unsigned GAP_W = $clog2(TIMEOUT_CLKS + 1);
    logic [GAP_W-1:0]    gap_q, gap_d;
`else
    logic                unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CLKS;
`endif

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        chk_d       = chk_q;
        idx_d       = idx_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        frame_len_d = frame_len_q;
`ifdef FRAME_TIMEOUT_EN
        gap_d       = '0;
`endif
        if (i_RX_DV) begin
            case (state_q)
                IDLE: begin
                    if (i_RX_Byte == SYNC_BYTE) begin
                        state_d = GET_LEN;
                    end
                end
                GET_LEN: begin
                    if (i_RX_Byte == 8'd0 || {1'b0, i_RX_Byte} > MAX_LEN_9) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        len_d   = i_RX_Byte;
                        chk_d   = i_RX_Byte;
                        idx_d   = '0;
                        state_d = GET_DATA;
                    end
                end
                GET_DATA: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = i_RX_Byte;
                    chk_d     = chk_q ^ i_RX_Byte;
                    idx_d     = idx_q + 1'b1;
                    if (8'(idx_q) == len_q - 8'd1) begin
                        state_d = GET_CHK;
                    end
                end
                GET_CHK: begin
                    if (i_RX_Byte == chk_q) begin
                        done_d      = 1'b1;
                        frame_len_d = len_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef FRAME_TIMEOUT_EN
        // A strobe in the expiry cycle takes the branch above, so it wins.
        else if (state_q != IDLE) begin
            if (gap_q == GAP_W'(TIMEOUT_CLKS - 1)) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
`endif
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= IDLE;
            len_q       <= '0;
            chk_q       <= '0;
            idx_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_len_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            chk_q       <= chk_d;
            idx_q       <= idx_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            frame_len_q <= frame_len_d;
        end
    end

`ifdef FRAME_TIMEOUT_EN
    // Inter-byte gap counter, idle outside a frame
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`endif

    assign o_Wr_En      = wr_en_q;
    assign o_Wr_Addr    = wr_addr_q;
    assign o_Wr_Data    = wr_data_q;
    assign o_Frame_Done = done_q;
    assign o_Frame_Err  = err_q;
    assign o_Frame_Len  = frame_len_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench for uart_frame_decoder: directed frames plus random
// traffic, checked against a frame-level reference model.
module tb_uart_frame_decoder;

    localparam int unsigned CPB     = 4;
    localparam int unsigned MAXL    = 64;
    localparam int unsigned TOB     = 1;
    localparam int unsigned TO_CLKS = TOB * 10 * CPB;
    localparam logic [7:0]  SYNC    = 8'hA5;
`ifdef FRAME_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done;
    logic       frame_err;
    logic [7:0] frame_len;

    uart_frame_decoder #(
        .CLKS_PER_BIT (CPB),
        .MAX_LEN      (MAXL),
        .SYNC_BYTE    (SYNC),
        .TIMEOUT_BYTES(TOB)
    ) dut (
        .i_Clock     (clk),
        .i_Rst_L     (rst_n),
        .i_RX_DV     (rx_dv),
        .i_RX_Byte   (rx_byte),
        .o_Wr_En     (wr_en),
        .o_Wr_Addr   (wr_addr),
        .o_Wr_Data   (wr_data),
        .o_Frame_Done(frame_done),
        .o_Frame_Err (frame_err),
        .o_Frame_Len (frame_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: bytes of the current frame after the sync byte
    bit         m_in_frame = 1'b0;
    logic [7:0] m_q[$];
    logic [7:0] m_last_len = 8'd0;
    int         m_gap = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame-level model: interprets the byte against the frame collected so far
    task automatic model_byte(input logic [7:0] b, output bit e_wr, output int e_addr,
                              output bit e_done, output bit e_err);
        int n;
        int len;
        logic [7:0] x;
        e_wr = 0; e_addr = 0; e_done = 0; e_err = 0;
        if (!m_in_frame) begin
            if (b == SYNC) begin
                m_in_frame = 1'b1;
                m_q.delete();
            end
        end else begin
            m_q.push_back(b);
            n   = m_q.size();
            len = int'(m_q[0]);
            if (n == 1) begin
                if (len == 0 || len > int'(MAXL)) begin
                    e_err = 1;
                    m_in_frame = 1'b0;
                end
            end else if (n <= len + 1) begin
                e_wr   = 1;
                e_addr = n - 2;
            end else begin
                x = 8'd0;
                for (int i = 0; i < n - 1; i++) x = x ^ m_q[i];
                if (x == b) begin
                    e_done = 1;
                    m_last_len = m_q[0];
                end else begin
                    e_err = 1;
                end
                m_in_frame = 1'b0;
            end
        end
    endtask

    // Idle cycles with no strobe; only a timeout may produce a pulse
    task automatic idle(input int n);
        bit e_err;
        repeat (n) begin
            @(posedge clk); #1;
            m_gap++;
            e_err = 0;
            if (TO_EN && m_in_frame && m_gap == int'(TO_CLKS)) begin
                e_err = 1;
                m_in_frame = 1'b0;
            end
            check("idle_wr_en", 32'(wr_en), 32'(0));
            check("idle_done", 32'(frame_done), 32'(0));
            check("idle_err", 32'(frame_err), 32'(e_err));
        end
    endtask

    // One receiver strobe followed by `gap` idle cycles (gap >= 1)
    task automatic send_b(input logic [7:0] b, input int gap);
        bit e_wr, e_done, e_err;
        int e_addr;
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        model_byte(b, e_wr, e_addr, e_done, e_err);
        m_gap = 0;
        @(posedge clk); #1;
        check("wr_en", 32'(wr_en), 32'(e_wr));
        if (e_wr) begin
            check("wr_addr", 32'(wr_addr), 32'(e_addr));
            check("wr_data", 32'(wr_data), 32'(b));
        end
        check("frame_done", 32'(frame_done), 32'(e_done));
        check("frame_err", 32'(frame_err), 32'(e_err));
        check("frame_len", 32'(frame_len), 32'(m_last_len));
        @(negedge clk);
        rx_dv   = 1'b0;
        rx_byte = 8'($urandom);
        idle(gap);
    endtask

    task automatic send_frame(input int len, input logic [7:0] corrupt, input int max_gap);
        logic [7:0] x;
        logic [7:0] p;
        send_b(SYNC, $urandom_range(1, max_gap));
        send_b(8'(len), $urandom_range(1, max_gap));
        x = 8'(len);
        for (int i = 0; i < len; i++) begin
            p = 8'($urandom);
            x = x ^ p;
            send_b(p, $urandom_range(1, max_gap));
        end
        send_b(x ^ corrupt, $urandom_range(1, max_gap));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en), 32'(0));
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'(0));
        check({tag, "_wr_data"}, 32'(wr_data), 32'(0));
        check({tag, "_done"}, 32'(frame_done), 32'(0));
        check({tag, "_err"}, 32'(frame_err), 32'(0));
        check({tag, "_len"}, 32'(frame_len), 32'(0));
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_in_frame = 1'b0;
        m_last_len = 8'd0;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_dv   = 1'b0;
        rx_byte = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Good frame, then the same frame with a bad checksum
        send_b(8'hA5, 2); send_b(8'h03, 2); send_b(8'h11, 2);
        send_b(8'h22, 2); send_b(8'h33, 2); send_b(8'h03, 3);
        send_b(8'hA5, 2); send_b(8'h03, 2); send_b(8'h11, 2);
        send_b(8'h22, 2); send_b(8'h33, 2); send_b(8'h00, 3);

        // Junk before sync, zero length, over-long length, maximum length
        send_b(8'h00, 1); send_b(8'hFF, 1); send_b(8'hA5, 1); send_b(8'h00, 2);
        send_b(8'hA5, 1); send_b(8'd65, 2);
        send_frame(64, 8'h00, 1);

        // Sync value as payload, back-to-back frames at minimum spacing
        send_b(8'hA5, 1); send_b(8'h02, 1); send_b(8'hA5, 1);
        send_b(8'hA5, 1); send_b(8'h02, 1);
        send_b(8'hA5, 1); send_b(8'h01, 1); send_b(8'h5A, 1); send_b(8'h5B, 1);

        // Reset after one of three payload bytes, then a clean frame
        send_b(8'hA5, 2); send_b(8'h03, 2); send_b(8'h11, 1);
        do_reset();
        send_frame(3, 8'h00, 3);

        // Stall mid-frame: timeout pulse if built in, otherwise silence
        send_b(8'hA5, 2); send_b(8'h02, 2); send_b(8'h11, 60);
        do_reset();

        // Random traffic
        for (int k = 0; k < 30; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                send_b(8'($urandom_range(0, 255)) == SYNC ? 8'h5A : 8'($urandom_range(0, 255)),
                       $urandom_range(1, 4));
            end else if (r < 3) begin
                send_b(SYNC, $urandom_range(1, 4));
                send_b(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(65, 255)),
                       $urandom_range(1, 4));
            end else begin
                send_frame($urandom_range(0, 3) == 0 ? $urandom_range(1, 64) : $urandom_range(1, 12),
                           ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                           5);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
